// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the issue stage and the ALU.
// Contents: ALU op encodings ({funct7[5], funct3}), RV32 major opcodes,
// and the packed issue bundle handed from decode to the ALU.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_t         op;
    logic [4:0]      rd;
    logic            wen;
    logic            illegal;
  } issue_t;

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I decode of one instruction into an ALU issue bundle.
// Ports:
//   instr   - instruction word
//   pc      - instruction PC (AUIPC operand a)
//   rs1_val - x[instr[19:15]]
//   rs2_val - x[instr[24:20]]
//   bundle  - decoded a/b/op/rd/wen/illegal
// Illegal instructions yield a=b=0, op=ADD, wen=0, illegal=1.
module alu_issue_dec
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output issue_t          bundle
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    bundle    = '0;
    bundle.op = ALU_ADD;
    bundle.rd = instr[11:7];
    legal     = 1'b0;

    case (opcode)
      OPC_OP: begin
        legal = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        bundle.a  = rs1_val;
        bundle.b  = rs2_val;
        bundle.op = alu_op_t'({funct7[5], funct3});
      end
      OPC_OP_IMM: begin
        bundle.a = rs1_val;
        case (funct3)
          3'b001: begin
            legal     = (funct7 == 7'b0000000);
            bundle.b  = {27'd0, instr[24:20]};
            bundle.op = ALU_SLL;
          end
          3'b101: begin
            legal     = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            bundle.b  = {27'd0, instr[24:20]};
            bundle.op = alu_op_t'({funct7[5], funct3});
          end
          default: begin
            legal     = 1'b1;
            bundle.b  = {{20{instr[31]}}, instr[31:20]};
            bundle.op = alu_op_t'({1'b0, funct3});
          end
        endcase
      end
      OPC_LUI: begin
        legal    = 1'b1;
        bundle.b = {instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        legal    = 1'b1;
        bundle.a = pc;
        bundle.b = {instr[31:12], 12'd0};
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      bundle.a  = '0;
      bundle.b  = '0;
      bundle.op = ALU_ADD;
    end
    bundle.illegal = !legal;
    bundle.wen     = legal && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/alu_issue.sv
// RV32I decode/issue stage feeding the combinational ALU through a single
// valid/ready output register.
// Ports:
//   i_clk, i_rst_n            - clock (rising), async active-low reset
//   i_valid / o_ready         - upstream handshake (o_ready = !o_valid || i_ready)
//   i_instr, i_pc             - instruction and its PC
//   i_rs1_val, i_rs2_val      - register-file read values
//   i_flush                   - drop held and incoming instruction
//   o_valid / i_ready         - downstream handshake
//   o_a, o_b, o_op            - ALU operands and opcode
//   o_rd, o_wen, o_illegal    - destination, write enable, illegal flag
// Optional (ALU_ISSUE_PERF_CNT_EN): o_cnt_issued, o_cnt_illegal count
// retired bundles and retired illegal bundles, wrapping at 2^32.
module alu_issue
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_a,
  output logic [XLEN-1:0] o_b,
  output logic [3:0]      o_op,
  output logic [4:0]      o_rd,
  output logic            o_wen,
`ifdef ALU_ISSUE_PERF_CNT_EN
  output logic [31:0]     o_cnt_issued,
  output logic [31:0]     o_cnt_illegal,
`endif
  output logic            o_illegal
);

  issue_t dec;
  issue_t held;
  logic   valid;
  logic   accept;

  alu_issue_dec u_dec (
    .instr   (i_instr),
    .pc      (i_pc),
    .rs1_val (i_rs1_val),
    .rs2_val (i_rs2_val),
    .bundle  (dec)
  );

  assign o_ready = !valid || i_ready;
  assign accept  = i_valid && o_ready && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid <= 1'b0;
      held  <= '0;
    end else if (i_flush) begin
      valid <= 1'b0;
    end else if (accept) begin
      valid <= 1'b1;
      held  <= dec;
    end else if (i_ready) begin
      valid <= 1'b0;
    end
  end

  assign o_valid   = valid;
  assign o_a       = held.a;
  assign o_b       = held.b;
  assign o_op      = held.op;
  assign o_rd      = held.rd;
  assign o_wen     = held.wen;
  assign o_illegal = held.illegal;

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic retire;
  assign retire = valid && i_ready && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt_issued  <= '0;
      o_cnt_illegal <= '0;
    end else if (retire) begin
      o_cnt_issued <= o_cnt_issued + 32'd1;
      if (held.illegal) o_cnt_illegal <= o_cnt_illegal + 32'd1;
    end
  end
`endif

endmodule
